masked_add_seq: RTL
===================

MASKED_ADD_SEQ -- requirements
Module: masked_add_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning limb width in bits (one pass of the masked N-bit ripple-carry slice).
REQ-002 The block SHALL have parameter K, default 4, meaning limb count; operand width W = N*K.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port clear  input  1  synchronous abort of any operation in progress.
REQ-006 The block SHALL have port in_valid  input  1  request carries a valid operand set.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-008 The block SHALL have ports a0, a1, b0, b1  input  W  Boolean shares; a = a0^a1, b = b0^b1.
REQ-009 The block SHALL have port c_in  input  1  carry into limb 0.
REQ-010 The block SHALL have port rnd  input  W+1  fresh mask for the output shares.
REQ-011 The block SHALL have port out_valid  output  1  result shares are valid.
REQ-012 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 The block SHALL have ports sum0, sum1  output  W+1  result shares; sum0^sum1 = a + b + c_in, with the final carry in bit W.
REQ-014 The block SHALL have port busy  output  1  high in state RUN.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = (state==RUN).
REQ-016 In IDLE with in_valid=1, the block SHALL, on that edge, capture a0, a1, b0, b1, c_in and rnd, load the carry register with c_in, set limb index i=0, and enter RUN.
REQ-017 In RUN, each cycle SHALL process limb i: shares are recombined per bit inside the slice only, the N-bit limb sum is written to result bits [i*N +: N], and the carry register takes the limb carry-out.
REQ-018 i SHALL increment by 1 per RUN cycle; the edge that processes limb K-1 SHALL write the final carry to result bit W and enter DONE.
REQ-019 Latency SHALL be exactly K cycles: out_valid rises K edges after the accepting edge.
REQ-020 In DONE, the block SHALL drive sum0 = result ^ captured rnd and sum1 = captured rnd, both registered and stable until the handshake.
REQ-021 In DONE, the edge with out_ready=1 SHALL return the FSM to IDLE; in_ready is high from the following cycle, and no request is accepted in the same cycle as the result handshake.
REQ-022 in_valid SHALL be ignored outside IDLE; operand inputs may change freely after acceptance without affecting the result.
REQ-023 clear=1 SHALL force IDLE on the next edge from any state, discard partial results, and zero the carry register and i; clear SHALL override in_valid and out_ready in the same cycle.
REQ-024 Addition SHALL be modulo 2^(W+1): no overflow flag, and the carry-out of limb K-1 is always kept in bit W.
REQ-025 Case K=1 SHALL give one RUN cycle; i SHALL never exceed K-1.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state IDLE, i=0, carry=0, result and captured rnd to 0, giving in_ready=1, out_valid=0, busy=0, sum0=0 and sum1=0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL drop the operation with no result emitted; the first request after release SHALL be handled normally.

Verification (N=4, K=4)
REQ-028 The bench SHALL cover: a0=0xFFFF, a1=0xEDCB (a=0x1234), b0=0x0FFF, b1=0, c_in=0, rnd=0 -> out_valid 4 cycles after accept, sum0=0x02233, sum1=0.
REQ-029 The bench SHALL cover: a=0xFFFF, b=0x0001, c_in=0, rnd=0x15555 -> sum0^sum1=0x10000, sum1=0x15555.
REQ-030 The bench SHALL cover: a=0, b=0, c_in=1 -> sum0^sum1=0x00001, with busy high for exactly 4 cycles.
REQ-031 The bench SHALL cover: out_ready held low 3 cycles in DONE -> sum0 and sum1 stable, in_ready=0, in_valid ignored; IDLE follows the cycle after out_ready=1.
REQ-032 The bench SHALL cover: rst pulsed while i=2 -> outputs at reset values asynchronously, no out_valid pulse; the next request returns a correct sum.
REQ-033 The bench SHALL cover: clear asserted together with out_ready in DONE -> IDLE next cycle, out_valid=0, carry register=0.

Source files
------------

// File: rtl/masked_add_seq.sv
// Two-share masked adder, one N-bit limb per cycle; result after K cycles in DONE.
// Valid/ready on both sides: request taken only in IDLE, result held until out_ready.
module masked_add_seq #(
   parameter int N = 4,
   parameter int K = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*K-1:0]   a0,
   input  logic [N*K-1:0]   a1,
   input  logic [N*K-1:0]   b0,
   input  logic [N*K-1:0]   b1,
   input  logic             c_in,
   input  logic [N*K:0]     rnd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N*K:0]     sum0,
   output logic [N*K:0]     sum1,
   output logic             busy
);

   localparam int W  = N * K;
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   logic [W-1:0]   a0_r, a1_r, b0_r, b1_r;
   logic [W:0]     rnd_r;
   logic [W:0]     result;
   logic           carry;
   logic [IW-1:0]  idx;

   logic [31:0]    base;
   logic [N-1:0]   a_limb, b_limb;
   logic [N:0]     limb_sum;
   logic           last;
   logic [W:0]     res_nxt;

   assign base = 32'(idx) * 32'(N);
   assign last = (idx == IW'(K - 1));

   // Shares are only recombined here, one limb at a time.
   always_comb begin
      a_limb   = a0_r[base +: N] ^ a1_r[base +: N];
      b_limb   = b0_r[base +: N] ^ b1_r[base +: N];
      limb_sum = {1'b0, a_limb} + {1'b0, b_limb} + {{N{1'b0}}, carry};
      res_nxt  = result;
      res_nxt[base +: N] = limb_sum[N-1:0];
      if (last)
         res_nxt[W] = limb_sum[N];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a0_r   <= '0;
         a1_r   <= '0;
         b0_r   <= '0;
         b1_r   <= '0;
         rnd_r  <= '0;
         result <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         sum0   <= '0;
         sum1   <= '0;
      end else if (clear) begin
         state  <= IDLE;
         rnd_r  <= '0;
         result <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         sum0   <= '0;
         sum1   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a0_r   <= a0;
                  a1_r   <= a1;
                  b0_r   <= b0;
                  b1_r   <= b1;
                  rnd_r  <= rnd;
                  carry  <= c_in;
                  result <= '0;
                  idx    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               result <= res_nxt;
               carry  <= limb_sum[N];
               if (last) begin
                  // Outputs are remasked on the final limb edge so DONE presents registered shares.
                  sum0  <= res_nxt ^ rnd_r;
                  sum1  <= rnd_r;
                  idx   <= '0;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN);

endmodule
